// File: rtl/alsu_param.sv
// Parametrised ALSU: registered inputs and outputs (2-cycle latency, 1 op/cycle),
// sticky error flag and a cycle-counted LED blink on invalid operations.
module alsu_param #(
  parameter int    WIDTH          = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_BLINK_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic [2:0]           opcode,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 err,
  output logic [15:0]          leds
);

  localparam int OW = 2 * WIDTH;
  localparam int CW = (LED_BLINK_CYC > 1) ? $clog2(LED_BLINK_CYC) : 1;
  localparam logic [CW-1:0] CntLast = CW'(LED_BLINK_CYC - 1);
  localparam bit PriA   = (INPUT_PRIORITY == "A");
  localparam bit AddCin = (FULL_ADDER == "ON");

  typedef enum logic [0:0] {StIdle, StBlink} state_e;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       opcode_q;
  logic             cin_q, sin_q, dir_q;
  logic             byp_a_q, byp_b_q, red_a_q, red_b_q;
  logic             v1_q;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;

  logic [OW-1:0]    a_ext, b_ext, res;
  logic             res_err, red_sel_a, red_any;

  // Stage 1: input capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= '0;
      cin_q    <= 1'b0;
      sin_q    <= 1'b0;
      dir_q    <= 1'b0;
      byp_a_q  <= 1'b0;
      byp_b_q  <= 1'b0;
      red_a_q  <= 1'b0;
      red_b_q  <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        a_q      <= A;
        b_q      <= B;
        opcode_q <= opcode;
        cin_q    <= cin;
        sin_q    <= serial_in;
        dir_q    <= direction;
        byp_a_q  <= bypass_A;
        byp_b_q  <= bypass_B;
        red_a_q  <= red_op_A;
        red_b_q  <= red_op_B;
      end
    end
  end

  // Stage-2 result decode from the registered inputs
  always_comb begin
    a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    res       = '0;
    res_err   = 1'b0;
    red_any   = red_a_q || red_b_q;
    red_sel_a = red_a_q && (!red_b_q || PriA);
    if (byp_a_q || byp_b_q) begin
      res = (byp_a_q && (!byp_b_q || PriA)) ? a_ext : b_ext;
    end else if (opcode_q[2:1] == 2'b11 || (red_any && opcode_q[2:1] != 2'b00)) begin
      res_err = 1'b1;
    end else begin
      case (opcode_q)
        3'd0: res = red_any ? {{(OW-1){1'b0}}, red_sel_a ? |a_q : |b_q} : (a_ext | b_ext);
        3'd1: res = red_any ? {{(OW-1){1'b0}}, red_sel_a ? ^a_q : ^b_q} : (a_ext ^ b_ext);
        3'd2: res = a_ext + b_ext + {{(OW-1){1'b0}}, cin_q & AddCin};
        3'd3: res = $signed(a_ext) * $signed(b_ext);
        // SHIFT/ROTATE operate on the current output so consecutive ops chain
        3'd4: res = dir_q ? {out[OW-2:0], sin_q} : {sin_q, out[OW-1:1]};
        3'd5: res = dir_q ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
        default: res = '0;
      endcase
    end
  end

  // Stage 2 output registers and error/LED state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      leds      <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        out   <= res;
        err   <= res_err;
        cnt_q <= '0;
        if (res_err) begin
          state_q <= StBlink;
          leds    <= 16'hFFFF;
        end else begin
          state_q <= StIdle;
          leds    <= '0;
        end
      end else if (state_q == StBlink) begin
        if (cnt_q == CntLast) begin
          cnt_q <= '0;
          leds  <= ~leds;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alsu_param.sv
// Directed bench for alsu_param: scoreboard of expected results checked when out_valid fires.
module tb_alsu_param;

  logic        clk, rst, in_valid, cin, serial_in, direction;
  logic        bypass_A, bypass_B, red_op_A, red_op_B;
  logic [7:0]  A, B;
  logic [2:0]  opcode;
  logic [15:0] out, leds;
  logic        out_valid, err;

  typedef struct {
    logic [15:0] out;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  alsu_param #(
    .WIDTH(8),
    .INPUT_PRIORITY("A"),
    .FULL_ADDER("ON"),
    .LED_BLINK_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .cin(cin),
    .serial_in(serial_in),
    .direction(direction),
    .opcode(opcode),
    .bypass_A(bypass_A),
    .bypass_B(bypass_B),
    .red_op_A(red_op_A),
    .red_op_B(red_op_B),
    .out(out),
    .out_valid(out_valid),
    .err(err),
    .leds(leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  // Drive one op at a falling edge; result is due two rising edges later.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic sin, input logic dir,
                       input logic ba, input logic bb, input logic ra, input logic rb,
                       input logic [15:0] exp_out, input logic exp_err);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    opcode    = op;
    A         = a;
    B         = b;
    cin       = c;
    serial_in = sin;
    direction = dir;
    bypass_A  = ba;
    bypass_B  = bb;
    red_op_A  = ra;
    red_op_B  = rb;
    e.out = exp_out;
    e.err = exp_err;
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_out", 32'(out), 32'(e.out));
        check("sb_err", 32'(err), 32'(e.err));
        check("sb_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; opcode = 3'd2; A = 8'd5; B = 8'd7; cin = 1'b1;
    serial_in = 1'b0; direction = 1'b0;
    bypass_A = 1'b0; bypass_B = 1'b0; red_op_A = 1'b0; red_op_B = 1'b0;

    // Reset held for two edges with in_valid high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_leds", 32'(leds), 32'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;

    // op     A      B      cin sin dir bA bB rA rB  expected  err
    issue(3'd2, 8'd100, 8'd50, 1, 0, 0, 0, 0, 0, 0, 16'd151,  0);
    issue(3'd2, 8'h80,  8'h80, 0, 0, 0, 0, 0, 0, 0, 16'hFF00, 0);
    issue(3'd3, 8'hFD,  8'd5,  0, 0, 0, 0, 0, 0, 0, 16'hFFF1, 0);
    issue(3'd3, 8'h80,  8'h80, 0, 0, 0, 0, 0, 0, 0, 16'h4000, 0);
    issue(3'd2, 8'd1,   8'd0,  0, 0, 0, 0, 0, 0, 0, 16'h0001, 0);
    issue(3'd4, 8'd0,   8'd0,  0, 1, 1, 0, 0, 0, 0, 16'h0003, 0);
    issue(3'd5, 8'd0,   8'd0,  0, 0, 0, 0, 0, 0, 0, 16'h8001, 0);
    issue(3'd4, 8'd0,   8'd0,  0, 0, 0, 0, 0, 0, 0, 16'h4000, 0);
    issue(3'd2, 8'h80,  8'h01, 0, 0, 0, 1, 1, 0, 0, 16'hFF80, 0);
    issue(3'd0, 8'h01,  8'h7F, 0, 0, 0, 0, 1, 0, 0, 16'h007F, 0);
    issue(3'd1, 8'h07,  8'h03, 0, 0, 0, 0, 0, 1, 1, 16'h0001, 0);
    issue(3'd0, 8'h00,  8'h10, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 0);
    issue(3'd1, 8'h0F,  8'hF0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0);
    issue(3'd0, 8'h01,  8'h02, 0, 0, 0, 0, 0, 0, 0, 16'h0003, 0);

    // Invalid opcode, then watch the blink pattern with no further ops
    issue(3'd6, 8'h12,  8'h34, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1);
    idle();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("blink_leds", 32'(leds), (k < 4 || k >= 8) ? 32'hFFFF : 32'h0000);
      check("blink_err", 32'(err), 32'd1);
    end

    issue(3'd0, 8'h01,  8'h02, 0, 0, 0, 0, 0, 0, 0, 16'h0003, 0);
    idle();
    @(negedge clk);
    check("clear_leds", 32'(leds), 32'd0);
    check("clear_err", 32'(err), 32'd0);

    issue(3'd2, 8'h05,  8'h06, 1, 0, 0, 0, 0, 1, 0, 16'h0000, 1);
    idle();
    @(negedge clk);
    check("red_add_leds", 32'(leds), 32'hFFFF);

    for (int i = 0; i < 4; i++) idle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
